// File: rtl/svnet_window_pkg.sv
// Shared sizing helpers for the svnet sliding-window generator.
package svnet_window_pkg;

    function automatic int window_bits(input int width, input int k);
        return width * k * k;
    endfunction

    // Bit offset of window element (row i, column j) in the flattened window.
    function automatic int elem_offset(input int i, input int j, input int k, input int width);
        return (i * k + j) * width;
    endfunction

    function automatic int frame_windows(input int img_w, input int img_h, input int k);
        return (img_w - k + 1) * (img_h - k + 1);
    endfunction

endpackage

// File: rtl/svnet_line_ram.sv
// Cascaded (K-1)-line pixel store: one column read and shifted per accepted pixel.
module svnet_line_ram #(
    parameter int WIDTH = 8,
    parameter int IMG_W = 8,
    parameter int K     = 3,
    parameter int COL_W = 3
) (
    input  logic                     clk,
    input  logic                     shift_en,
    input  logic [COL_W-1:0]         col,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [(K-1)*WIDTH-1:0]   rd_col
);

    // Storage is deliberately not reset; the window logic never emits stale lines.
    logic [WIDTH-1:0] line_mem [K-1][IMG_W];

    always_ff @(posedge clk) begin
        if (shift_en) begin
            line_mem[0][col] <= wr_data;
            for (int i = 1; i < K - 1; i++) begin
                line_mem[i][col] <= line_mem[i-1][col];
            end
        end
    end

    always_comb begin
        rd_col = '0;
        for (int i = 0; i < K - 1; i++) begin
            rd_col[i*WIDTH +: WIDTH] = line_mem[i][col];
        end
    end

endmodule

// File: rtl/svnet_window_gen.sv
// Streams raster pixels from one svnet FIFO and pushes KxK stride-1 valid windows into the next.
module svnet_window_gen
    import svnet_window_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int K     = 3,
    parameter int DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [$clog2(DEPTH):0]            in_used_space,
    input  logic [WIDTH-1:0]                  in_read_data,
    output logic                              in_read,
    input  logic [$clog2(DEPTH):0]            out_free_space,
    output logic                              out_write,
    output logic [window_bits(WIDTH, K)-1:0]  out_write_data,
    output logic                              end_of_frame
);

    localparam int SPACE_W = $clog2(DEPTH) + 1;
    localparam int WIN_W   = window_bits(WIDTH, K);
    localparam int COL_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W   = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0] COL_WIN0 = COL_W'(K - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0] ROW_WIN0 = ROW_W'(K - 1);

    if (K < 2) begin : g_bad_k
        $error("svnet_window_gen: K must be >= 2");
    end
    if (IMG_W < K) begin : g_bad_w
        $error("svnet_window_gen: IMG_W must be >= K");
    end
    if (IMG_H < K) begin : g_bad_h
        $error("svnet_window_gen: IMG_H must be >= K");
    end

    logic [COL_W-1:0]         col_q, col_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic [WIN_W-1:0]         win_q, win_d;
    logic                     out_write_q, out_write_d;
    logic                     eof_q, eof_d;
    logic [(K-1)*WIDTH-1:0]   lb_col;
    logic [K*WIDTH-1:0]       col_vec;

    // A write already in flight still needs its downstream slot, so reserve it.
    assign in_read = (in_used_space != '0)
                   && (out_free_space > {{(SPACE_W-1){1'b0}}, out_write_q});

    svnet_line_ram #(
        .WIDTH (WIDTH),
        .IMG_W (IMG_W),
        .K     (K),
        .COL_W (COL_W)
    ) u_line_ram (
        .clk      (clk),
        .shift_en (in_read),
        .col      (col_q),
        .wr_data  (in_read_data),
        .rd_col   (lb_col)
    );

    // Oldest line at index 0, incoming pixel at index K-1.
    always_comb begin
        col_vec = '0;
        col_vec[(K-1)*WIDTH +: WIDTH] = in_read_data;
        for (int i = 0; i < K - 1; i++) begin
            col_vec[i*WIDTH +: WIDTH] = lb_col[(K-2-i)*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        win_d = win_q;
        if (in_read) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K - 1; j++) begin
                    win_d[elem_offset(i, j, K, WIDTH) +: WIDTH] =
                        win_q[elem_offset(i, j + 1, K, WIDTH) +: WIDTH];
                end
                win_d[elem_offset(i, K - 1, K, WIDTH) +: WIDTH] = col_vec[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        out_write_d = 1'b0;
        eof_d       = 1'b0;
        if (in_read) begin
            out_write_d = (row_q >= ROW_WIN0) && (col_q >= COL_WIN0);
            eof_d       = out_write_d && (row_q == ROW_LAST) && (col_q == COL_LAST);
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            win_q       <= '0;
            out_write_q <= 1'b0;
            eof_q       <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            win_q       <= win_d;
            out_write_q <= out_write_d;
            eof_q       <= eof_d;
        end
    end

    assign out_write      = out_write_q;
    assign out_write_data = win_q;
    assign end_of_frame   = eof_q;

    a_write_has_space : assert property (@(posedge clk) disable iff (!rst_n)
        out_write |-> (out_free_space != '0));
    a_read_has_data : assert property (@(posedge clk) disable iff (!rst_n)
        in_read |-> (in_used_space != '0));

endmodule

// File: doc/svnet_window_gen.md
Name: svnet_window_gen

Overview:
- Sliding-window generator between two svnet RAM FIFOs in the conv datapath.
- Pops one raster-order pixel per accepted cycle from an upstream FIFO and pushes K×K stride-1 "valid" (unpadded) windows into a downstream FIFO.
- Holds K-1 image lines internally.
- Uses the same free_space/used_space handshake as the FIFO so it chains directly.

Parameters:
- WIDTH, 8, bits per pixel.
- IMG_W, 8, image width in pixels; must be >= K.
- IMG_H, 8, image height in pixels; must be >= K.
- K, 3, window edge; must be >= 2.
- DEPTH, 4, depth of both neighbouring FIFOs; sets the space-port width.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- in_used_space, in, $clog2(DEPTH)+1, upstream FIFO occupancy.
- in_read_data, in, WIDTH, upstream head pixel; show-ahead, valid whenever in_used_space != 0.
- in_read, out, 1, pops upstream head this cycle.
- out_free_space, in, $clog2(DEPTH)+1, downstream FIFO free entries.
- out_write, out, 1, pushes out_write_data this cycle.
- out_write_data, out, WIDTH*K*K, flattened window.
- end_of_frame, out, 1, pulses together with the last window of a frame.

Behaviour:
- Reset (async assert, sync release):
  - out_write=0, out_write_data=0, end_of_frame=0.
  - col=0, row=0, window registers=0.
  - Line RAM contents are not reset; stale contents never reach an emitted window.
- Accept condition: in_read = (in_used_space != 0) && (out_free_space > out_write).
  - This reserves a slot for a write already in flight, so the downstream FIFO never overflows.
  - in_read is combinational; nothing else changes on cycles with in_read=0.
- On an accepted pixel p at (row, col):
  - Column vector v[0..K-1] = {lb[K-2][col], ..., lb[0][col], p}, oldest row first.
  - Line RAM update: lb[0][col] <= p; lb[i][col] <= lb[i-1][col]. Read-before-write in the same cycle.
  - Window update: win[i][j] <= win[i][j+1] for j < K-1; win[i][K-1] <= v[i].
  - Counters: col increments and wraps IMG_W-1 -> 0. On that wrap row increments and wraps IMG_H-1 -> 0.
- Emit: when the accepted pixel has row >= K-1 and col >= K-1:
  - next cycle, out_write=1 for exactly one cycle;
  - out_write_data = updated window, element win[i][j] at bits [(i*K+j)*WIDTH +: WIDTH];
  - latency is 1 cycle from in_read.
- end_of_frame=1 in the same cycle as the out_write for pixel (IMG_H-1, IMG_W-1); otherwise 0.
- Windows per frame = (IMG_W-K+1)*(IMG_H-K+1).
- Frames are back-to-back. No flush is needed; the first K-1 rows of the next frame emit nothing.
- The window shift register is not cleared at a row start. Windows at col < K-1 are suppressed, so stale columns never appear.
- Simultaneous pop and push: allowed every cycle. Sustained throughput is 1 pixel/clk while both FIFOs keep up.
- Empty upstream or full downstream: stall with all state held; out_write drops to 0 after any in-flight write.
- Reset mid-frame: next pixel accepted after release is treated as (0,0).
- Assertions:
  - out_write |-> out_free_space != 0
  - in_read |-> in_used_space != 0
  - parameter checks on K, IMG_W, IMG_H at elaboration.

Decomposition:
- Package svnet_window_pkg:
  - window_bits(WIDTH,K) function;
  - window element offset function (i,j,K,WIDTH);
  - frame window-count function, used by the bench.
- Sub-module svnet_line_ram: the (K-1)×IMG_W×WIDTH cascaded line store.
  - One column read/shift per accepted pixel.
  - Read-before-write.
  - No reset on storage.

Test Plan (WIDTH=8, IMG_W=IMG_H=4, K=3, DEPTH=4 unless noted):
- Pixels 0..15 streamed, downstream always free:
  - exactly 4 writes, at the cycles after pixels 10, 11, 14, 15;
  - first window rows {0,1,2},{4,5,6},{8,9,10};
  - last window rows {5,6,7},{9,10,11},{13,14,15} with end_of_frame=1.
- Two frames back-to-back, pixel = frame*16 + index: 8 windows; the 5th window rows {16,17,18},{20,21,22},{24,25,26}; no cross-frame mixing.
- Downstream out_free_space held at 1 from pixel 10: at most one write in flight; no in_read while out_write=1 and free_space=1; window contents unchanged once space returns.
- Upstream in_used_space toggling 1/0 every cycle: same 4 windows and values as the first scenario; in_read never asserted while in_used_space=0.
- rst_n asserted after pixel 9 of frame 1, then a fresh frame 0..15: outputs clear immediately; exactly 4 windows with the first scenario's values.
- IMG_W=5, IMG_H=3, K=2: 8 windows; window for pixel 6 is rows {0,1},{5,6}; end_of_frame with window {8,9},{13,14}.
